// File: rtl/gpu_pkg.sv
// ============================================================================
//  gpu_pkg
//  Shared screen defaults, framebuffer entry type and writer state encoding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package gpu_pkg;

    localparam int c_screen_w = 640;
    localparam int c_screen_h = 480;
    localparam int c_addr_w   = 19;
    localparam int c_color_w  = 16;

    typedef struct packed {
        logic [c_addr_w-1:0]  addr;
        logic [c_color_w-1:0] color;
    } fb_entry_t;

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_REQ  = 1'b1;

    // Full-width linear address; callers truncate to their address width.
    function automatic logic [31:0] linear_addr(input logic [15:0] x,
                                                input logic [15:0] y,
                                                input int unsigned width);
        return 32'(y) * width + 32'(x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
// ============================================================================
//  pixel_fifo
//  Synchronous FIFO with registered storage, occupancy count and flags.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot a push needs when full.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/raster_pixel_writer.sv
// ============================================================================
//  raster_pixel_writer
//  Dedups, clips and buffers rasterizer pixels, then drains them to the
//  framebuffer over req/ack. Optional clipping: define PIXEL_CLIP_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module raster_pixel_writer
    import gpu_pkg::*;
#(
    parameter int SCREEN_W   = c_screen_w,
    parameter int SCREEN_H   = c_screen_h,
    parameter int ADDR_W     = c_addr_w,
    parameter int COLOR_W    = c_color_w,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [15:0]        pix_x,
    input  logic [15:0]        pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               tri_done,
    output logic               pix_ready,
    output logic               fb_req,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ack,
    output logic               busy,
    output logic [15:0]        drop_cnt
);

    localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_entry_w = ADDR_W + COLOR_W;

    logic                      r_tri_d;
    logic                      w_tri_rise;
    logic                      r_last_valid;
    logic [15:0]               r_last_x;
    logic [15:0]               r_last_y;
    logic                      w_accept;
    logic                      w_dup;
    logic                      w_keep;
    logic [ADDR_W-1:0]         w_addr;

    logic                      r_s1_valid;
    logic [ADDR_W-1:0]         r_s1_addr;
    logic [COLOR_W-1:0]        r_s1_color;

    logic                      w_fifo_push;
    logic [c_entry_w-1:0]      w_fifo_head;
    logic [c_cnt_w-1:0]        w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [c_cnt_w:0]          w_occ;

    logic [0:0]                r_state;
    logic [0:0]                w_state_next;
    logic                      w_load;

    assign w_tri_rise = tri_done & ~r_tri_d;
    assign w_accept   = pix_valid & pix_ready;
    assign w_dup      = r_last_valid & (pix_x == r_last_x) & (pix_y == r_last_y);
    assign w_addr     = ADDR_W'(linear_addr(pix_x, pix_y, SCREEN_W));

`ifdef PIXEL_CLIP_EN
    localparam logic [31:0] c_lim_w = 32'(SCREEN_W);
    localparam logic [31:0] c_lim_h = 32'(SCREEN_H);

    logic        w_clip;
    logic [15:0] r_drop_cnt;

    assign w_clip   = (32'(pix_x) >= c_lim_w) | (32'(pix_y) >= c_lim_h);
    assign w_keep   = w_accept & ~w_dup & ~w_clip;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept & w_clip & (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
`else
    assign w_keep   = w_accept & ~w_dup;
    assign drop_cnt = 16'd0;
`endif

    // A tri_done edge wins over a same-cycle keep: the next triangle starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tri_d      <= 1'b0;
            r_last_valid <= 1'b0;
            r_last_x     <= '0;
            r_last_y     <= '0;
        end else begin
            r_tri_d <= tri_done;
            if (w_tri_rise) begin
                r_last_valid <= 1'b0;
            end else if (w_keep) begin
                r_last_valid <= 1'b1;
                r_last_x     <= pix_x;
                r_last_y     <= pix_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_color <= '0;
        end else begin
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1_addr  <= w_addr;
                r_s1_color <= pix_color;
            end
        end
    end

    // Stage 1 is counted in the occupancy, so it always finds a free slot.
    assign w_occ       = {1'b0, w_fifo_count} + {{c_cnt_w{1'b0}}, r_s1_valid};
    assign pix_ready   = (w_occ < (c_cnt_w+1)'(FIFO_DEPTH));
    assign w_fifo_push = r_s1_valid & (~w_fifo_full | w_load);

    pixel_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_fifo_push),
        .push_data ({r_s1_addr, r_s1_color}),
        .pop       (w_load),
        .head      (w_fifo_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WR_IDLE: if (!w_fifo_empty)          w_state_next = WR_REQ;
            WR_REQ:  if (fb_ack && w_fifo_empty) w_state_next = WR_IDLE;
            default:                             w_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        fb_req = 1'b0;
        w_load = 1'b0;
        case (r_state)
            WR_IDLE: w_load = ~w_fifo_empty;
            WR_REQ: begin
                fb_req = 1'b1;
                w_load = fb_ack & ~w_fifo_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr <= '0;
            fb_data <= '0;
        end else if (w_load) begin
            fb_addr <= w_fifo_head[c_entry_w-1:COLOR_W];
            fb_data <= w_fifo_head[COLOR_W-1:0];
        end
    end

    assign busy = r_s1_valid | (w_fifo_count != '0) | fb_req;

endmodule

`default_nettype wire

// File: tb/tb_raster_pixel_writer.sv
// ============================================================================
//  tb_raster_pixel_writer
//  Scoreboard bench: a reference model queues expected writes as pixels are
//  accepted; a monitor pops and compares each acknowledged write.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_raster_pixel_writer;

    typedef struct packed {
        logic [18:0] addr;
        logic [15:0] color;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_color;
    logic        tri_done;
    logic        pix_ready;
    logic        fb_req;
    logic [18:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_ack;
    logic        busy;
    logic [15:0] drop_cnt;

    exp_t        sb_q[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    bit          m_last_valid = 1'b0;
    int          m_last_x = 0;
    int          m_last_y = 0;
    int          m_drop   = 0;

    always #5 clk = ~clk;

    raster_pixel_writer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .tri_done  (tri_done),
        .pix_ready (pix_ready),
        .fb_req    (fb_req),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_ack    (fb_ack),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    // Reference model of one accepted pixel.
    task automatic model_accept(input int x, input int y, input logic [15:0] c);
        bit   clip;
        exp_t e;
        int unsigned p;
`ifdef PIXEL_CLIP_EN
        clip = (x >= 640) || (y >= 480);
`else
        clip = 1'b0;
`endif
        if (m_last_valid && x == m_last_x && y == m_last_y) begin
            return;
        end
        if (clip) begin
            if (m_drop < 65535) m_drop++;
            return;
        end
        p       = y * 640 + x;
        e.addr  = 19'(p);
        e.color = c;
        sb_q.push_back(e);
        m_last_valid = 1'b1;
        m_last_x     = x;
        m_last_y     = y;
    endtask

    always @(negedge clk) begin
        if (!rst && fb_req && fb_ack) begin
            exp_t e;
            n_writes++;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL write: unexpected addr=%0d data=%h, none expected", fb_addr, fb_data);
            end else begin
                e = sb_q.pop_front();
                if (fb_addr !== e.addr || fb_data !== e.color) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             fb_addr, fb_data, e.addr, e.color);
                end
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send_pixel(input int x, input int y, input logic [15:0] c);
        bit done = 1'b0;
        pix_x = 16'(x); pix_y = 16'(y); pix_color = c; pix_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (pix_ready) begin
                model_accept(x, y, c);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: pixel (%0d,%0d) not accepted", x, y);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain: busy=%0b pending=%0d, expected idle with 0 pending", busy, sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
        tri_done = 1'b0; fb_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", pix_ready); end
        n_tests++;
        if (fb_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, expected 0", fb_req); end
        n_tests++;
        if (fb_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, expected 0", fb_addr); end
        n_tests++;
        if (fb_data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %0d, expected 0", fb_data); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_tests++;
        if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d, expected 0", drop_cnt); end
        n_tests++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        fb_ack = 1'b1;
        send_pixel(10, 2, 16'hBEEF);          // accepted at edge N
        @(negedge clk);                       // after N
        if (fb_req !== 1'b0) begin n_fail++; $display("FAIL lat_n: fb_req got %b, expected 0", fb_req); end
        n_tests++;
        @(negedge clk);                       // after N+1
        if (fb_req !== 1'b0) begin n_fail++; $display("FAIL lat_n1: fb_req got %b, expected 0", fb_req); end
        n_tests++;
        @(negedge clk);                       // after N+2
        if (fb_req !== 1'b1 || fb_addr !== 19'd1290) begin
            n_fail++;
            $display("FAIL lat_n2: fb_req=%b addr=%0d, expected req=1 addr=1290", fb_req, fb_addr);
        end
        n_tests++;
        @(negedge clk);                       // after ack edge N+3
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, expected 0", busy); end
        n_tests++;
        @(posedge clk); #1;
    endtask

    task automatic test_dup();
        int w0 = n_writes;
        fb_ack = 1'b1;
        for (int i = 0; i < 3; i++) send_pixel(5, 5, 16'h0505);
        send_pixel(6, 5, 16'h0605);
        wait_idle();
        check("dup_writes", 32'(n_writes - w0), 32'd2);
        check("dup_drop", 32'(drop_cnt), 32'd0);
    endtask

    task automatic test_clip();
        int w0 = n_writes;
        fb_ack = 1'b1;
        send_pixel(640, 0, 16'h1111);
        send_pixel(0, 480, 16'h2222);
        send_pixel(639, 479, 16'h3333);
        wait_idle();
`ifdef PIXEL_CLIP_EN
        check("clip_writes", 32'(n_writes - w0), 32'd1);
        check("clip_drop", 32'(drop_cnt), 32'd2);
`else
        check("clip_writes", 32'(n_writes - w0), 32'd3);
        check("clip_drop", 32'(drop_cnt), 32'd0);
`endif
    endtask

    task automatic test_full();
        int idx = 0;
        int run = 0;
        int w0  = n_writes;
        fb_ack = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            pix_valid = 1'b1; pix_x = 16'(idx); pix_y = 16'd10; pix_color = 16'(idx * 257 + 1);
            @(negedge clk);
            if (pix_ready) begin
                model_accept(idx, 10, 16'(idx * 257 + 1));
                idx++;
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        @(negedge clk);
        // Output register + 8 FIFO entries; stage 1 has drained into the FIFO.
        check("full_accepts", 32'(idx), 32'd9);
        check("full_ready", 32'(pix_ready), 32'd0);
        check("full_head_addr", 32'(fb_addr), 32'd6400);
        check("full_req", 32'(fb_req), 32'd1);
        @(posedge clk); #1;
        fb_ack = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (fb_req) run++;
            else break;
        end
        check("full_burst", 32'(run), 32'd9);
        wait_idle();
        check("full_writes", 32'(n_writes - w0), 32'd9);
    endtask

    task automatic test_tri();
        int w0 = n_writes;
        fb_ack = 1'b1;
        send_pixel(3, 3, 16'hA003);
        tri_done = 1'b1;
        @(posedge clk); #1;
        tri_done = 1'b0;
        m_last_valid = 1'b0;
        send_pixel(3, 3, 16'hB003);
        // tri_done edge coincides with a duplicate: still compared against old value.
        tri_done = 1'b1;
        send_pixel(3, 3, 16'hC003);
        m_last_valid = 1'b0;
        tri_done = 1'b0;
        send_pixel(3, 3, 16'hD003);
        wait_idle();
        check("tri_writes", 32'(n_writes - w0), 32'd3);
    endtask

    task automatic test_reset_mid();
        int w0;
        int reqs = 0;
        fb_ack = 1'b0;
        for (int i = 0; i < 5; i++) send_pixel(i, 20, 16'(16'h4000 + i));
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("mid_req_before", 32'(fb_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        m_last_valid = 1'b0;
        m_drop = 0;
        w0 = n_writes;
        @(negedge clk);
        check("mid_req", 32'(fb_req), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;
        fb_ack = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (fb_req) reqs++;
        end
        check("mid_no_req", 32'(reqs), 32'd0);
        check("mid_no_writes", 32'(n_writes - w0), 32'd0);
        check("mid_drop", 32'(drop_cnt), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_dup();
        test_clip();
        test_full();
        test_tri();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
